// File: rtl/spi_serializer_tx.sv
// rtl/spi_serializer_tx.sv - SPI-style word serializer paced by clk_10mhz edge ticks; SPI_PARITY_EN appends an even-parity bit
module spi_serializer_tx #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              clk_10mhz,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);

`ifdef SPI_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CNT_W = $clog2(NBITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, FINISH} state_t;

    state_t           state_q;
    logic [NBITS-1:0] shift_q;
    logic [NBITS-1:0] shift_d;
    logic [NBITS-1:0] frame_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             clk_prev_q;
    logic             tx_ready_q, sclk_q, mosi_q, cs_n_q, busy_q, done_q;
    logic             rise_t, fall_t, first_bit, next_bit;

    // clk_10mhz shares the clk_100mhz domain, so a single delay register gives clean ticks
    assign rise_t =  clk_10mhz & ~clk_prev_q;
    assign fall_t = ~clk_10mhz &  clk_prev_q;

    // Parity always travels last, so it sits at the end opposite the first data bit
    always_comb begin
`ifdef SPI_PARITY_EN
        if (MSB_FIRST) frame_d = {tx_data, ^tx_data};
        else           frame_d = {^tx_data, tx_data};
`else
        frame_d = tx_data;
`endif
        if (MSB_FIRST) begin
            first_bit = frame_d[NBITS-1];
            shift_d   = {shift_q[NBITS-2:0], 1'b0};
            next_bit  = shift_d[NBITS-1];
        end else begin
            first_bit = frame_d[0];
            shift_d   = {1'b0, shift_q[NBITS-1:1]};
            next_bit  = shift_d[0];
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            clk_prev_q <= 1'b0;
            tx_ready_q <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clk_prev_q <= clk_10mhz;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid && tx_ready_q) begin
                        shift_q    <= frame_d;
                        mosi_q     <= first_bit;
                        cs_n_q     <= 1'b0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        bit_cnt_q  <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (fall_t) state_q <= SHIFT;
                end
                SHIFT: begin
                    if (rise_t) begin
                        sclk_q <= 1'b1;
                    end else if (fall_t) begin
                        sclk_q    <= 1'b0;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= FINISH;
                        end else begin
                            shift_q <= shift_d;
                            mosi_q  <= next_bit;
                        end
                    end
                end
                FINISH: begin
                    // Half a bit period of hold after the last falling edge before releasing cs_n
                    if (rise_t) begin
                        cs_n_q     <= 1'b1;
                        mosi_q     <= 1'b0;
                        done_q     <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_spi_serializer_tx.sv
// tb/tb_spi_serializer_tx.sv - scoreboard bench for spi_serializer_tx (MSB-first and LSB-first instances in lockstep)
module tb_spi_serializer_tx;
`ifdef SPI_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk10 = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, sclk, mosi, cs_n, busy, done;
    logic       tx_ready_l, sclk_l, mosi_l, cs_n_l, busy_l, done_l;

    int total = 0;
    int bad = 0;
    int frames_pushed = 0;
    int done_total = 0;

    typedef struct packed {
        logic [NB-1:0] m;
        logic [NB-1:0] l;
    } exp_t;
    exp_t exp_q[$];

    spi_serializer_tx #(.DATA_W(8), .MSB_FIRST(1'b1)) dut (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_10mhz(clk10),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
    );

    spi_serializer_tx #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_100mhz(clk), .rst_n(rst_n), .clk_10mhz(clk10),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_l),
        .sclk(sclk_l), .mosi(mosi_l), .cs_n(cs_n_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    // Divided clock: 5 cycles high, 5 low; frozen while stall is set
    int div = 0;
    always @(negedge clk) begin
        if (!stall) begin
            if (div == 4) begin
                div = 0;
                clk10 = ~clk10;
            end else begin
                div++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: collects mosi at each sclk rise and closes the frame when cs_n returns high
    logic          cs_p = 1'b1;
    logic          sclk_p = 1'b0;
    logic          active = 1'b0;
    int            nbits = 0, low_cnt = 0, high_cnt = 100, stall_cnt = 0, ready_err = 0, lock_err = 0;
    logic [NB-1:0] seq_m = '0;
    logic [NB-1:0] seq_l = '0;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (done) done_total++;
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            if (cs_p && !cs_n) begin
                check("cs_high_gap_ge1", 32'(high_cnt >= 1), 32'd1);
                active = 1'b1;
                nbits = 0; low_cnt = 0; stall_cnt = 0; ready_err = 0; lock_err = 0;
                seq_m = '0; seq_l = '0;
            end
            if (!cs_n) begin
                low_cnt++;
                high_cnt = 0;
                if (stall) stall_cnt++;
                if (tx_ready || !busy) ready_err++;
            end else begin
                high_cnt++;
            end
            if (sclk_l !== sclk || cs_n_l !== cs_n || tx_ready_l !== tx_ready ||
                busy_l !== busy || done_l !== done) lock_err++;
            if (sclk && !sclk_p) begin
                seq_m = {seq_m[NB-2:0], mosi};
                seq_l = {seq_l[NB-2:0], mosi_l};
                nbits++;
            end
            if (!cs_p && cs_n && active) begin
                if (exp_q.size() == 0) begin
                    check("frame_expected", 32'd0, 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bits_msb_first", 32'(seq_m), 32'(mon_e.m));
                    check("bits_lsb_first", 32'(seq_l), 32'(mon_e.l));
                end
                check("bit_count", 32'(nbits), 32'(NB));
                check("cs_low_min", 32'((low_cnt - stall_cnt) >= NB * 10 + 6), 32'd1);
                check("cs_low_max", 32'((low_cnt - stall_cnt) <= NB * 10 + 15), 32'd1);
                check("done_at_cs_rise", 32'(done), 32'd1);
                check("ready_low_busy_high", 32'(ready_err), 32'd0);
                check("lsb_lockstep", 32'(lock_err), 32'd0);
                active = 1'b0;
            end
        end
        cs_p = cs_n;
        sclk_p = sclk;
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tx_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // m/l are hand-written first-to-last transmitted bit orders; p is the hand-computed parity
    task automatic send(input logic [7:0] d, input logic [7:0] m, input logic [7:0] l,
                        input logic p, input bit expect_it, input bit hold);
        exp_t e;
        wait_ready();
        if (expect_it) begin
            e.m = NB'({m, p} >> (9 - NB));
            e.l = NB'({l, p} >> (9 - NB));
            exp_q.push_back(e);
            frames_pushed++;
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_rises(input int want, input string name);
        int n = 0;
        int rises = 0;
        logic prev = sclk;
        while (rises < want && n < 1000) begin
            @(posedge clk); #1;
            if (sclk && !prev) rises++;
            prev = sclk;
            n++;
        end
        check(name, 32'(rises), 32'(want));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && cs_n && !busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int changes;
        logic s0, m0, c0;

        repeat (3) @(posedge clk); #1;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // T1 plus a tx_valid pulse while busy that must not be consumed
        send(8'hA5, 8'b10100101, 8'b10100101, 1'b0, 1'b1, 1'b0);
        repeat (5) @(posedge clk); #1;
        tx_data = 8'h99;
        tx_valid = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("ready_low_midframe", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;

        // T2
        send(8'h01, 8'b00000001, 8'b10000000, 1'b1, 1'b1, 1'b0);
        check("ready_low_after_handshake", 32'(tx_ready), 32'd0);
        check("busy_after_handshake", 32'(busy), 32'd1);

        // T3: tx_valid stays high across both words
        send(8'h3C, 8'b00111100, 8'b00111100, 1'b0, 1'b1, 1'b1);
        tx_data = 8'hC3;
        send(8'hC3, 8'b11000011, 8'b11000011, 1'b0, 1'b1, 1'b0);

        // T4: reset mid-transfer
        wait_idle();
        send(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        wait_rises(3, "abort_three_rises");
        rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        send(8'h12, 8'b00010010, 8'b01001000, 1'b0, 1'b1, 1'b0);

        // T5: divider stalls mid-shift
        send(8'h07, 8'b00000111, 8'b11100000, 1'b1, 1'b1, 1'b0);
        wait_rises(2, "stall_two_rises");
        stall = 1'b1;
        s0 = sclk; m0 = mosi; c0 = cs_n;
        changes = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (sclk !== s0 || mosi !== m0 || cs_n !== c0 || busy !== 1'b1) changes++;
        end
        check("frozen_during_stall", 32'(changes), 32'd0);
        stall = 1'b0;

        send(8'h03, 8'b00000011, 8'b11000000, 1'b0, 1'b1, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk); #1;
        check("done_pulse_count", 32'(done_total), 32'(frames_pushed));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
